// File: rtl/instruction_decode_stage_pkg.sv
// Shared decode definitions: datapath width, immediate-format encodings, opcodes and the ID/EX entry.
// The entry carries an illegal flag only when DECODE_ILLEGAL_TRAP_EN is defined.
package instruction_decode_stage_pkg;

    localparam int XLEN          = 32;
    localparam int IMM_SEL_WIDTH = 2;

    typedef enum logic [IMM_SEL_WIDTH:0] {
        IMM_UNKNOWN_TYPE = 3'd0,
        IMM_I_TYPE       = 3'd1,
        IMM_S_TYPE       = 3'd2,
        IMM_B_TYPE       = 3'd3,
        IMM_U_TYPE       = 3'd4,
        IMM_J_TYPE       = 3'd5
    } imm_sel_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        imm_sel_e        sel;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic            illegal;
`endif
    } id_entry_t;

    function automatic imm_sel_e opcode_to_sel(input logic [6:0] opc);
        imm_sel_e sel;
        case (opc)
            OPC_LUI, OPC_AUIPC:                                      sel = IMM_U_TYPE;
            OPC_JAL:                                                 sel = IMM_J_TYPE;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: sel = IMM_I_TYPE;
            OPC_STORE:                                               sel = IMM_S_TYPE;
            OPC_BRANCH:                                              sel = IMM_B_TYPE;
            default:                                                 sel = IMM_UNKNOWN_TYPE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/instruction_decode_stage_if.sv
// Fetch->decode->execute handshake bundle; the decode stage uses the slave modport.
// o_Illegal exists only when DECODE_ILLEGAL_TRAP_EN is defined.
interface instruction_decode_stage_if;
    import instruction_decode_stage_pkg::*;

    logic                   i_Valid;
    logic                   o_Ready;
    logic [XLEN-1:0]        i_Instruction;
    logic [XLEN-1:0]        i_PC;
    logic                   o_Valid;
    logic                   i_Ready;
    logic [XLEN-1:0]        o_PC;
    logic [XLEN-1:0]        o_Immediate;
    logic [IMM_SEL_WIDTH:0] o_Imm_Select;
    logic [6:0]             o_Opcode;
    logic [4:0]             o_Rd;
    logic [4:0]             o_Rs1;
    logic [4:0]             o_Rs2;
    logic [2:0]             o_Funct3;
    logic [6:0]             o_Funct7;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                   o_Illegal;
`endif

    modport slave (
        input  i_Valid, i_Instruction, i_PC, i_Ready,
        output o_Ready, o_Valid, o_PC, o_Immediate, o_Imm_Select, o_Opcode,
               o_Rd, o_Rs1, o_Rs2, o_Funct3, o_Funct7
`ifdef DECODE_ILLEGAL_TRAP_EN
        , output o_Illegal
`endif
    );

    modport master (
        output i_Valid, i_Instruction, i_PC, i_Ready,
        input  o_Ready, o_Valid, o_PC, o_Immediate, o_Imm_Select, o_Opcode,
               o_Rd, o_Rs1, o_Rs2, o_Funct3, o_Funct7
`ifdef DECODE_ILLEGAL_TRAP_EN
        , input o_Illegal
`endif
    );

endinterface

// File: rtl/instruction_decode_stage_immediate_unit.sv
// Combinational RISC-V immediate former: selects the I/S/B/U/J layout of instr[31:7].
module immediate_unit
    import instruction_decode_stage_pkg::*;
(
    input  imm_sel_e        i_Imm_Select,
    input  logic [XLEN-1:7] i_Instr,
    output logic [XLEN-1:0] o_Immediate
);

    always_comb begin
        o_Immediate = '0;
        case (i_Imm_Select)
            IMM_I_TYPE: o_Immediate = {{20{i_Instr[31]}}, i_Instr[31:20]};
            IMM_S_TYPE: o_Immediate = {{20{i_Instr[31]}}, i_Instr[31:25], i_Instr[11:7]};
            IMM_B_TYPE: o_Immediate = {{19{i_Instr[31]}}, i_Instr[31], i_Instr[7],
                                       i_Instr[30:25], i_Instr[11:8], 1'b0};
            IMM_U_TYPE: o_Immediate = {i_Instr[31:12], 12'b0};
            IMM_J_TYPE: o_Immediate = {{11{i_Instr[31]}}, i_Instr[31], i_Instr[19:12],
                                       i_Instr[20], i_Instr[30:21], 1'b0};
            default:    o_Immediate = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decode_stage.sv
// Decode stage: decodes fetch entries into the ID/EX register behind a 2-entry skid buffer.
// Optional illegal-instruction flag enabled by defining DECODE_ILLEGAL_TRAP_EN.
module instruction_decode_stage
    import instruction_decode_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Flush,
    instruction_decode_stage_if.slave  bus
);

    imm_sel_e        sel_c;
    logic [XLEN-1:0] imm_c;
    id_entry_t       in_c;
    id_entry_t       rst_entry;
    id_entry_t       main_q, main_d, skid_q, skid_d;
    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            ready_q, ready_d;
    logic            accept, drain;

    assign sel_c = opcode_to_sel(bus.i_Instruction[6:0]);

    immediate_unit u_immediate_unit (
        .i_Imm_Select (sel_c),
        .i_Instr      (bus.i_Instruction[XLEN-1:7]),
        .o_Immediate  (imm_c)
    );

    always_comb begin
        in_c        = '0;
        in_c.pc     = bus.i_PC;
        in_c.imm    = imm_c;
        in_c.sel    = sel_c;
        in_c.opcode = bus.i_Instruction[6:0];
        in_c.rd     = bus.i_Instruction[11:7];
        in_c.rs1    = bus.i_Instruction[19:15];
        in_c.rs2    = bus.i_Instruction[24:20];
        in_c.funct3 = bus.i_Instruction[14:12];
        in_c.funct7 = bus.i_Instruction[31:25];
`ifdef DECODE_ILLEGAL_TRAP_EN
        // every listed opcode ends in 2'b11, so an unknown select also covers the low-bit check
        in_c.illegal = (bus.i_Instruction[1:0] != 2'b11) ||
                       ((sel_c == IMM_UNKNOWN_TYPE) && (bus.i_Instruction[6:0] != OPC_OP));
`endif
    end

    always_comb begin
        rst_entry    = '0;
        rst_entry.pc = RESET_PC;
    end

    assign accept = bus.i_Valid & ready_q;
    assign drain  = main_valid_q & bus.i_Ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (i_Flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain || !main_valid_q) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = in_c;
            end else begin
                main_valid_d = accept;
                if (accept) main_d = in_c;
            end
        end else if (accept) begin
            skid_d       = in_c;
            skid_valid_d = 1'b1;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            main_q       <= rst_entry;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.o_Ready      = ready_q;
    assign bus.o_Valid      = main_valid_q;
    assign bus.o_PC         = main_q.pc;
    assign bus.o_Immediate  = main_q.imm;
    assign bus.o_Imm_Select = main_q.sel;
    assign bus.o_Opcode     = main_q.opcode;
    assign bus.o_Rd         = main_q.rd;
    assign bus.o_Rs1        = main_q.rs1;
    assign bus.o_Rs2        = main_q.rs2;
    assign bus.o_Funct3     = main_q.funct3;
    assign bus.o_Funct7     = main_q.funct7;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign bus.o_Illegal    = main_q.illegal;
`endif

endmodule
